// File: rtl/dt_window_scheduler.sv
// -----------------------------------------------------------------------------
// dt_window_scheduler
//
// Sequences decision-tree evaluation over the packet buffer, one parser window
// at a time. Window k is considered filled when the NIC write pointer reaches
// the first byte of the following window. An edge detect turns that into a
// single trigger. Each trigger pulses the tree start, and every per-window
// drop result is ORed into one per-packet verdict. The verdict is held to the
// NIC TX side until it is acknowledged.
//
// Optional feature: define DT_WATCHDOG_EN to add a per-evaluation watchdog.
// When it expires, the window is treated as a drop and err_timeout is set.
// Without the macro the block waits for dt_done indefinitely and err_timeout
// is tied low.
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   receiving      in   NIC packet reception active
//   byte_offset    in   [1:0] NIC byte position in word
//   word_offset    in   [4:0] NIC word position in buffer
//   dt_done        in   decision tree result valid (1-cycle pulse)
//   dt_drop        in   decision tree drop result, valid with dt_done
//   tx_ok          in   NIC accepted the verdict
//   dt_start       out  1-cycle start pulse to decision tree
//   win_sel        out  [1:0] parser window index (0 = first window)
//   busy           out  packet evaluation in progress
//   verdict_valid  out  per-packet verdict available
//   verdict_drop   out  OR of all window drop results
//   err_timeout    out  sticky: watchdog expired
//   err_overrun    out  sticky: a window trigger was lost
// -----------------------------------------------------------------------------
module dt_window_scheduler #(
  parameter int BUF_WORDS      = 20,
  parameter int WORDS_PER_WIN  = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       receiving,
  input  logic [1:0] byte_offset,
  input  logic [4:0] word_offset,
  input  logic       dt_done,
  input  logic       dt_drop,
  input  logic       tx_ok,
  output logic       dt_start,
  output logic [1:0] win_sel,
  output logic       busy,
  output logic       verdict_valid,
  output logic       verdict_drop,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int         NUM_WIN  = BUF_WORDS / WORDS_PER_WIN;
  localparam logic [1:0] LAST_WIN = 2'(NUM_WIN - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  // Reject configurations the 2-bit window index and 5-bit word offset
  // cannot represent.
  if (NUM_WIN < 1 || NUM_WIN > 4 || (BUF_WORDS % WORDS_PER_WIN) != 0 ||
      BUF_WORDS > 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("dt_window_scheduler: unsupported parameter combination");
  end

  logic [2:0] r_state;
  logic [1:0] r_win_idx;
  logic       r_acc;
  logic       r_pending;
  logic [3:0] r_match_q;
  logic       r_err_overrun;

  logic [3:0] w_match;
  logic [3:0] w_trig;
  logic       w_trig_cur;
  logic       w_trig_next;
  logic       w_in_eval;
  logic       w_overrun;
  logic       w_set_pending;
  logic       w_timeout;
  logic       w_win_end;
  logic       w_acc_set;

  // Window k is full once the writer sits on byte 0 of the next window.
  // The last window wraps to word 0.
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    w_match = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < NUM_WIN) begin
        w_match[k] = (byte_offset == 2'd0) &&
                     (word_offset == 5'(((k + 1) * WORDS_PER_WIN) % BUF_WORDS));
      end
    end
  end

  // Rising edge only: a writer parked on a boundary produces one trigger.
  assign w_trig      = w_match & ~r_match_q;
  assign w_trig_cur  = w_trig[r_win_idx];
  assign w_trig_next = (r_win_idx != LAST_WIN) && w_trig[r_win_idx + 2'd1];

  // Early triggers for the next window are remembered once. A second
  // trigger while one is still queued means a window was lost, so the
  // packet is failed closed.
  assign w_in_eval     = (r_state == S_START) || (r_state == S_WAIT);
  assign w_set_pending = w_in_eval && !r_pending && w_trig_next;
  assign w_overrun     = w_in_eval && r_pending && (|w_trig);

  assign w_win_end = ((r_state == S_WAIT) && dt_done) || w_timeout;
  assign w_acc_set = w_overrun || w_timeout ||
                     ((r_state == S_WAIT) && dt_done && dt_drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      r_state       <= S_IDLE;
      r_win_idx     <= 2'd0;
      r_acc         <= 1'b0;
      r_pending     <= 1'b0;
      r_match_q     <= 4'd0;
      r_err_overrun <= 1'b0;
    end else begin
      r_match_q <= w_match;

      if (w_overrun) begin
        r_err_overrun <= 1'b1;
      end

      if (r_state == S_IDLE) begin
        r_acc <= 1'b0;
      end else if (w_acc_set) begin
        r_acc <= 1'b1;
      end

      // ARM always consumes a queued trigger, so clearing there is exact.
      if (r_state == S_IDLE || r_state == S_ARM) begin
        r_pending <= 1'b0;
      end else if (w_set_pending) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_win_idx <= 2'd0;
          if (receiving) begin
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          // A filled window takes precedence over end of reception so its
          // data is still evaluated.
          if (w_trig_cur || r_pending) begin
            r_state <= S_START;
          end else if (!receiving) begin
            r_state <= S_REPORT;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_win_end) begin
            if (r_win_idx == LAST_WIN || !receiving) begin
              r_state <= S_REPORT;
            end else begin
              r_win_idx <= r_win_idx + 2'd1;
              r_state   <= S_ARM;
            end
          end
        end
        S_REPORT: begin
          if (tx_ok) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DT_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_err_timeout;

  // The counter is zeroed in START, so it reads 0 on the first WAIT cycle.
  // The limit is reached on WAIT cycle number TIMEOUT_CYCLES.
  assign w_timeout = (r_state == S_WAIT) && !dt_done &&
                     (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (r_state == S_START) begin
        r_wd_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign dt_start      = (r_state == S_START);
  assign win_sel       = r_win_idx;
  assign busy          = (r_state != S_IDLE);
  assign verdict_valid = (r_state == S_REPORT);
  assign verdict_drop  = (r_state == S_REPORT) && r_acc;
  assign err_overrun   = r_err_overrun;

endmodule
